// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - 4-digit multiplexed 7-segment scanner with per-frame digit snapshot
// Slots run mX, mU, sX, sU; each slot is a dead-time BLANK phase followed by an ACTIVE phase.
module seg_scan #(
   parameter int CLK_HZ     = 50000000,
   parameter int SCAN_HZ    = 1000,
   parameter int BLANK_CYC  = 500,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] dis_mx_i,
   input  logic [3:0] dis_mu_i,
   input  logic [3:0] dis_sx_i,
   input  logic [3:0] dis_su_i,
   input  logic       sec_tick_i,
   input  logic       blank_lz_i,
   output logic [6:0] seg_o,
   output logic       dp_o,
   output logic [3:0] an_o
);

   localparam int DIV     = CLK_HZ / SCAN_HZ;
   localparam int ACT_CYC = DIV - BLANK_CYC;
   localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] ACT_LAST   = CW'(ACT_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic [3:0] AN_OFF  = {4{ACTIVE_LOW}};
   localparam logic       DP_OFF  = ACTIVE_LOW;

   typedef enum logic {
      ST_BLANK,
      ST_ACTIVE
   } phase_e;

   phase_e        phase_q;
   logic [1:0]    idx_q;
   logic [CW-1:0] cnt_q;

   logic [3:0] mx_q, mu_q, sx_q, su_q;
   logic [3:0] mx_d, mu_d, sx_d, su_d;
   logic       colon_q, colon_d;
   logic       colon_sh_q, colon_sh_d;
   logic       blz_q, blz_d;

   logic [6:0] seg_q, seg_d;
   logic       dp_q, dp_d;
   logic [3:0] an_q, an_d;

   logic       blank_end;
   logic       active_end;
   logic       snap;
   logic [1:0] idx_nx;
   logic [3:0] digit;
   logic       lit;

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h40;
      endcase
      return p;
   endfunction

   // idx names the slot that just finished; it advances as the next slot goes ACTIVE.
   always_comb begin
      blank_end  = (phase_q == ST_BLANK) && (cnt_q == BLANK_LAST);
      active_end = (phase_q == ST_ACTIVE) && (cnt_q == ACT_LAST);
      idx_nx     = idx_q + 2'd1;
      snap       = blank_end && (idx_nx == 2'd0);

      mx_d       = snap ? dis_mx_i   : mx_q;
      mu_d       = snap ? dis_mu_i   : mu_q;
      sx_d       = snap ? dis_sx_i   : sx_q;
      su_d       = snap ? dis_su_i   : su_q;
      blz_d      = snap ? blank_lz_i : blz_q;
      colon_sh_d = snap ? colon_q    : colon_sh_q;
      colon_d    = colon_q ^ sec_tick_i;

      case (idx_nx)
         2'd0:    digit = mx_d;
         2'd1:    digit = mu_d;
         2'd2:    digit = sx_d;
         default: digit = su_d;
      endcase
      lit = !((idx_nx == 2'd0) && blz_d && (mx_d == 4'd0));

      seg_d = seg_q;
      dp_d  = dp_q;
      an_d  = an_q;
      if (blank_end) begin
         if (lit) begin
            an_d  = (4'b1000 >> idx_nx) ^ AN_OFF;
            seg_d = seg_pattern(digit) ^ SEG_OFF;
            dp_d  = ((idx_nx == 2'd1) && colon_sh_d) ^ DP_OFF;
         end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
         end
      end else if (active_end) begin
         an_d  = AN_OFF;
         seg_d = SEG_OFF;
         dp_d  = DP_OFF;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q    <= ST_BLANK;
         idx_q      <= 2'd3;
         cnt_q      <= '0;
         mx_q       <= 4'd0;
         mu_q       <= 4'd0;
         sx_q       <= 4'd0;
         su_q       <= 4'd0;
         blz_q      <= 1'b0;
         colon_q    <= 1'b0;
         colon_sh_q <= 1'b0;
         seg_q      <= SEG_OFF;
         dp_q       <= DP_OFF;
         an_q       <= AN_OFF;
      end else begin
         mx_q       <= mx_d;
         mu_q       <= mu_d;
         sx_q       <= sx_d;
         su_q       <= su_d;
         blz_q      <= blz_d;
         colon_q    <= colon_d;
         colon_sh_q <= colon_sh_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         case (phase_q)
            ST_BLANK: begin
               if (blank_end) begin
                  phase_q <= ST_ACTIVE;
                  idx_q   <= idx_nx;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               if (active_end) begin
                  phase_q <= ST_BLANK;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
         endcase
      end
   end

   assign seg_o = seg_q;
   assign dp_o  = dp_q;
   assign an_o  = an_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan against a cycle-count display model
// The model derives slot/phase from the number of clock edges since reset release.
module tb_seg_scan;

   localparam int DIV   = 10;
   localparam int BLK   = 2;
   localparam int FRAME = 4 * DIV;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] mx    = 4'd1;
   logic [3:0] mu    = 4'd2;
   logic [3:0] sx    = 4'd3;
   logic [3:0] su    = 4'd4;
   logic       tick  = 1'b0;
   logic       blz   = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] digit_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   seg_scan #(
      .CLK_HZ     (1000),
      .SCAN_HZ    (100),
      .BLANK_CYC  (BLK),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .dis_mx_i   (mx),
      .dis_mu_i   (mu),
      .dis_sx_i   (sx),
      .dis_su_i   (su),
      .sec_tick_i (tick),
      .blank_lz_i (blz),
      .seg_o      (seg),
      .dp_o       (dp),
      .an_o       (an)
   );

   always #5 clk = ~clk;

   // Reference model: edge count since release, plus the values captured at each frame start.
   int         m_k;
   int         m_ticks;
   logic [3:0] m_snap [4];
   logic       m_colon;
   logic       m_blz;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_k     <= 0;
         m_ticks <= 0;
         for (int i = 0; i < 4; i++) m_snap[i] <= 4'd0;
         m_colon <= 1'b0;
         m_blz   <= 1'b0;
      end else begin
         m_k <= m_k + 1;
         if ((m_k + 1) % FRAME == BLK) begin
            m_snap[0] <= mx;
            m_snap[1] <= mu;
            m_snap[2] <= sx;
            m_snap[3] <= su;
            m_colon   <= (m_ticks % 2) == 1;
            m_blz     <= blz;
         end
         if (tick) m_ticks <= m_ticks + 1;
      end
   end

   function automatic logic [6:0] pattern(input logic [3:0] d);
      if (d > 4'd9) return 7'h40;
      return digit_tbl[d];
   endfunction

   function automatic int cur_slot();
      return (m_k / DIV) % 4;
   endfunction

   function automatic bit exp_lit();
      if ((m_k % DIV) < BLK) return 1'b0;
      if (cur_slot() == 0 && m_blz && m_snap[0] == 4'd0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [3:0] exp_an();
      logic [3:0] onehot;
      onehot = 4'b1000 >> cur_slot();
      return exp_lit() ? ~onehot : 4'hF;
   endfunction

   function automatic logic [6:0] exp_seg();
      return exp_lit() ? ~pattern(m_snap[cur_slot()]) : 7'h7F;
   endfunction

   function automatic logic exp_dp();
      return (exp_lit() && cur_slot() == 1 && m_colon) ? 1'b0 : 1'b1;
   endfunction

   task automatic wait_pos(input int target);
      int guard;
      guard = 0;
      @(negedge clk);
      while ((m_k % FRAME) != target && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      n_tests++;
      if ((m_k % FRAME) != target) begin
         n_fail++;
         $display("FAIL wait_pos: reached pos %0d, required %0d", m_k % FRAME, target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      @(negedge clk);
      n_tests++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: an=%h seg=%h dp=%b, required an=f seg=7f dp=1", an, seg, dp);
      end
   endtask

   task automatic test_restart_sequence();
      logic [3:0] e_an;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 1; c <= 44; c++) begin
         @(negedge clk);
         e_an = ((c % 10) >= 2) ? ~(4'b1000 >> ((c / 10) % 4)) : 4'hF;
         n_tests++;
         if (an !== e_an) begin
            n_fail++;
            $display("FAIL restart_an cycle %0d: an=%b, required %b", c, an, e_an);
         end
         n_tests++;
         if (seg !== exp_seg() || dp !== exp_dp()) begin
            n_fail++;
            $display("FAIL restart_seg cycle %0d: seg=%h dp=%b, required seg=%h dp=%b",
                     c, seg, dp, exp_seg(), exp_dp());
         end
      end
   endtask

   task automatic test_digits();
      logic [6:0] req [4];
      logic [3:0] req_an [4];
      req    = '{7'h79, 7'h24, 7'h30, 7'h19};
      req_an = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
      mx = 4'd1; mu = 4'd2; sx = 4'd3; su = 4'd4; blz = 1'b0;
      wait_pos(FRAME - 5);
      for (int s = 0; s < 4; s++) begin
         wait_pos(s * DIV + BLK);
         n_tests++;
         if (seg !== req[s] || an !== req_an[s]) begin
            n_fail++;
            $display("FAIL digits slot %0d: seg=%h an=%b, required seg=%h an=%b",
                     s, seg, an, req[s], req_an[s]);
         end
      end
   endtask

   task automatic test_snapshot();
      wait_pos(BLK);
      wait_pos(DIV + 4);
      su = 4'd5;
      wait_pos(3 * DIV + BLK);
      n_tests++;
      if (seg !== 7'h19) begin
         n_fail++;
         $display("FAIL snapshot_same_frame: seg=%h, required 19", seg);
      end
      wait_pos(3 * DIV + BLK);
      n_tests++;
      if (seg !== 7'h12) begin
         n_fail++;
         $display("FAIL snapshot_next_frame: seg=%h, required 12", seg);
      end
      su = 4'd4;
   endtask

   task automatic test_leading_zero();
      wait_pos(20);
      mx = 4'd0; blz = 1'b1;
      wait_pos(BLK);
      for (int c = 0; c < DIV - BLK; c++) begin
         n_tests++;
         if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL lz_blank cycle %0d: an=%b seg=%h dp=%b, required 1111/7f/1", c, an, seg, dp);
         end
         @(negedge clk);
      end
      wait_pos(DIV + BLK);
      n_tests++;
      if (an !== 4'b1011 || seg !== 7'h24) begin
         n_fail++;
         $display("FAIL lz_mu_lit: an=%b seg=%h, required 1011/24", an, seg);
      end
      blz = 1'b0;
      wait_pos(BLK);
      n_tests++;
      if (an !== 4'b0111 || seg !== 7'h40) begin
         n_fail++;
         $display("FAIL lz_zero_shown: an=%b seg=%h, required 0111/40", an, seg);
      end
      mx = 4'hC;
      wait_pos(BLK);
      n_tests++;
      if (an !== 4'b0111 || seg !== 7'h3F) begin
         n_fail++;
         $display("FAIL dash: an=%b seg=%h, required 0111/3f", an, seg);
      end
      mx = 4'd1;
   endtask

   task automatic test_colon();
      logic e_dp;
      wait_pos(20);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      wait_pos(BLK);
      for (int c = 0; c < FRAME; c++) begin
         e_dp = ((m_k % FRAME) >= DIV + BLK && (m_k % FRAME) < 2 * DIV) ? 1'b0 : 1'b1;
         n_tests++;
         if (dp !== e_dp) begin
            n_fail++;
            $display("FAIL colon_on pos %0d: dp=%b, required %b", m_k % FRAME, dp, e_dp);
         end
         @(negedge clk);
      end
      wait_pos(20);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      wait_pos(BLK);
      for (int c = 0; c < FRAME; c++) begin
         n_tests++;
         if (dp !== 1'b1) begin
            n_fail++;
            $display("FAIL colon_off pos %0d: dp=%b, required 1", m_k % FRAME, dp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_tick_at_snapshot();
      wait_pos(BLK - 1);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      wait_pos(DIV + BLK);
      n_tests++;
      if (dp !== 1'b1) begin
         n_fail++;
         $display("FAIL tick_snap_same: dp=%b, required 1", dp);
      end
      wait_pos(DIV + BLK);
      n_tests++;
      if (dp !== 1'b0) begin
         n_fail++;
         $display("FAIL tick_snap_next: dp=%b, required 0", dp);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 12 * FRAME; c++) begin
         @(negedge clk);
         n_tests++;
         if (an !== exp_an() || seg !== exp_seg() || dp !== exp_dp()) begin
            n_fail++;
            $display("FAIL random k=%0d: an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                     m_k, an, seg, dp, exp_an(), exp_seg(), exp_dp());
         end
         tick = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 7) == 0) begin
            mx  = 4'($urandom_range(0, 15));
            mu  = 4'($urandom_range(0, 15));
            sx  = 4'($urandom_range(0, 15));
            su  = 4'($urandom_range(0, 15));
            blz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) mx = 4'd0;
         end
      end
      tick = 1'b0;
      mx = 4'd1; mu = 4'd2; sx = 4'd3; su = 4'd4; blz = 1'b0;
   endtask

   task automatic test_reset_mid();
      wait_pos(2 * DIV + BLK + 3);
      n_tests++;
      if (an !== 4'b1101) begin
         n_fail++;
         $display("FAIL mid_active: an=%b, required 1101", an);
      end
      #1;
      reset = 1'b1;
      #1;
      n_tests++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: an=%b seg=%h dp=%b, required 1111/7f/1", an, seg, dp);
      end
   endtask

   initial begin
      test_reset();
      test_restart_sequence();
      test_digits();
      test_snapshot();
      test_leading_zero();
      test_colon();
      test_tick_at_snapshot();
      test_random();
      wait_pos(0);
      test_reset_mid();
      test_restart_sequence();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
